// File: rtl/rs_cdb_station.sv
// Reservation station bank on the receiving end of the common data bus.
// Define RS_AGE_ORDER_EN to dispatch the oldest READY entry instead of the lowest-index one.
module rs_cdb_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_BASE    = 1,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [3:0]        issue_qj,
  input  logic [3:0]        issue_qk,
  output logic [3:0]        issue_tag,
  input  logic              cdb_valid,
  input  logic [3:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [OP_W-1:0]   exec_op,
  output logic [DATA_W-1:0] exec_a,
  output logic [DATA_W-1:0] exec_b,
  output logic [3:0]        exec_tag
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] r_busy;
  logic [OP_W-1:0]        r_op [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_vj [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_vk [NUM_ENTRIES];
  logic [3:0]             r_qj [NUM_ENTRIES];
  logic [3:0]             r_qk [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_ready;
  logic                   w_any_free;
  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_any_ready;
  logic [IDX_W-1:0]       w_sel_idx;
  logic                   w_issue_fire;
  logic                   w_disp_fire;
  logic                   w_cdb_hit;
  logic                   w_fwd_j;
  logic                   w_fwd_k;
  logic [DATA_W-1:0]      w_new_vj;
  logic [DATA_W-1:0]      w_new_vk;
  logic [3:0]             w_new_qj;
  logic [3:0]             w_new_qk;

  // Per-entry readiness from registered state only.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == 4'd0) && (r_qk[i] == 4'd0);
    end
  end

  // Lowest-index free entry (descending scan so the lowest index wins last).
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_free_idx = !r_busy[i] ? IDX_W'(i) : w_free_idx;
      w_any_free = w_any_free | !r_busy[i];
    end
  end

`ifdef RS_AGE_ORDER_EN
  localparam int AGE_W = $clog2(NUM_ENTRIES) + 1;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [AGE_W-1:0] r_age [NUM_ENTRIES];
  logic [AGE_W-1:0] w_best_age;
  logic             w_take;

  // Oldest READY entry; strict compare keeps ties on the lowest index.
  always_comb begin
    w_any_ready = 1'b0;
    w_sel_idx   = '0;
    w_best_age  = '0;
    w_take      = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_take      = w_ready[i] && (!w_any_ready || (r_age[i] > w_best_age));
      w_sel_idx   = w_take ? IDX_W'(i) : w_sel_idx;
      w_best_age  = w_take ? r_age[i] : w_best_age;
      w_any_ready = w_any_ready | w_ready[i];
    end
  end

  // Age bookkeeping: the new entry starts at 0, older busy entries saturate upward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_age[i] <= '0;
      end
    end else if (w_issue_fire) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_free_idx == IDX_W'(i)) begin
          r_age[i] <= '0;
        end else if (r_busy[i] && (r_age[i] != AGE_MAX)) begin
          r_age[i] <= r_age[i] + AGE_ONE;
        end else begin
          r_age[i] <= r_age[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_age[i] <= r_age[i];
      end
    end
  end
`else
  // Lowest-index READY entry.
  always_comb begin
    w_any_ready = |w_ready;
    w_sel_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_sel_idx = w_ready[i] ? IDX_W'(i) : w_sel_idx;
    end
  end
`endif

  assign w_issue_fire = issue_valid && w_any_free;
  assign w_disp_fire  = w_any_ready && exec_ready;
  assign w_cdb_hit    = cdb_valid && (cdb_tag != 4'd0);

  // A broadcast coinciding with issue is captured here, since the entry is not busy yet to snoop it.
  assign w_fwd_j  = w_cdb_hit && (issue_qj == cdb_tag);
  assign w_fwd_k  = w_cdb_hit && (issue_qk == cdb_tag);
  assign w_new_vj = w_fwd_j ? cdb_data : issue_vj;
  assign w_new_vk = w_fwd_k ? cdb_data : issue_vk;
  assign w_new_qj = w_fwd_j ? 4'd0 : issue_qj;
  assign w_new_qk = w_fwd_k ? 4'd0 : issue_qk;

  // Entry state: issue writes a free entry; snoop and dispatch act on busy entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_op[i] <= '0;
        r_vj[i] <= '0;
        r_vk[i] <= '0;
        r_qj[i] <= 4'd0;
        r_qk[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_issue_fire && (w_free_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= issue_op;
          r_vj[i]   <= w_new_vj;
          r_vk[i]   <= w_new_vk;
          r_qj[i]   <= w_new_qj;
          r_qk[i]   <= w_new_qk;
        end else begin
          if (w_disp_fire && (w_sel_idx == IDX_W'(i))) begin
            r_busy[i] <= 1'b0;
          end else begin
            r_busy[i] <= r_busy[i];
          end
          if (r_busy[i] && w_cdb_hit && (r_qj[i] == cdb_tag)) begin
            r_vj[i] <= cdb_data;
            r_qj[i] <= 4'd0;
          end else begin
            r_vj[i] <= r_vj[i];
            r_qj[i] <= r_qj[i];
          end
          if (r_busy[i] && w_cdb_hit && (r_qk[i] == cdb_tag)) begin
            r_vk[i] <= cdb_data;
            r_qk[i] <= 4'd0;
          end else begin
            r_vk[i] <= r_vk[i];
            r_qk[i] <= r_qk[i];
          end
        end
      end
    end
  end

  assign issue_ready = w_any_free;
  assign issue_tag   = w_any_free ? 4'(TAG_BASE + int'(w_free_idx)) : 4'd0;
  assign exec_valid  = w_any_ready;
  assign exec_op     = w_any_ready ? r_op[w_sel_idx] : '0;
  assign exec_a      = w_any_ready ? r_vj[w_sel_idx] : '0;
  assign exec_b      = w_any_ready ? r_vk[w_sel_idx] : '0;
  assign exec_tag    = w_any_ready ? 4'(TAG_BASE + int'(w_sel_idx)) : 4'd0;

endmodule
